// File: rtl/mod_exp_pkg.sv
// Shared types and helpers for the streaming modular exponentiation engine.
//   state_t   : control FSM encoding
//   msb_index : position of the highest set bit (0 when the value is 0)
package mod_exp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_SQR    = 3'd2,
    ST_MUL    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Widest operand msb_index can scan; callers zero-extend into this width.
  localparam int unsigned MSB_MAX_W = 128;

  function automatic int unsigned msb_index(input logic [MSB_MAX_W-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned k = 0; k < MSB_MAX_W; k++) begin
      if (v[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Serial modular multiplier: product = a * b mod m, interleaved shift-add,
// multiplier bit b MSB first, one bit per cycle, W cycles per product.
// The first step is taken on the start edge itself so back-to-back products
// chain without idle cycles.
//   clk, rst_n : clock, async active-low reset
//   start      : launch a product using a, b, m (sampled on this edge)
//   a, b, m    : multiplicand (must be < m), multiplier, modulus
//   done       : one-cycle pulse, product valid while high
//   product    : result register
module mod_mul_serial #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         done,
  output logic [W-1:0] product
);
  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  a_q, b_sh, m_q, acc;
  logic [CW-1:0] cnt;
  logic          running;

  logic [W-1:0]  step_a_c, step_m_c, step_acc_c;
  logic          step_bit_c;
  logic [W:0]    t_dbl_c, t_red_c, t_add_c, t_out_c;

  // One reduction step; on start the fresh operands are used directly.
  always_comb begin
    step_a_c   = start ? a : a_q;
    step_m_c   = start ? m : m_q;
    step_acc_c = start ? '0 : acc;
    step_bit_c = start ? b[W-1] : b_sh[W-1];
    t_dbl_c    = {step_acc_c, 1'b0};
    t_red_c    = (t_dbl_c >= {1'b0, step_m_c}) ? (t_dbl_c - {1'b0, step_m_c}) : t_dbl_c;
    t_add_c    = step_bit_c ? (t_red_c + {1'b0, step_a_c}) : t_red_c;
    t_out_c    = (t_add_c >= {1'b0, step_m_c}) ? (t_add_c - {1'b0, step_m_c}) : t_add_c;
  end

  // Accumulator, operand latches and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_sh    <= '0;
      m_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= t_out_c[W-1:0];
        a_q     <= a;
        m_q     <= m;
        b_sh    <= {b[W-2:0], 1'b0};
        cnt     <= CW'(W - 1);
        running <= 1'b1;
      end else if (running) begin
        acc  <= t_out_c[W-1:0];
        b_sh <= {b_sh[W-2:0], 1'b0};
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/mod_exp_stream.sv
// Streaming modular exponentiation: result = base^exponent mod modulo,
// left-to-right square-and-multiply over a shared serial multiplier.
//   clk, reset          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_ready only in IDLE)
//   base/modulo/exponent: operands, W = 2*ARQ bits
//   out_valid/out_ready : result handshake, result held until taken
//   result, out_error   : result (0 on error), modulo==0 flag
//   busy                : engine not idle
// Operand width is limited to mod_exp_pkg::MSB_MAX_W.
module mod_exp_stream
  import mod_exp_pkg::*;
#(
  parameter int unsigned ARQ          = 16,
  parameter bit          SKIP_LEADING = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*ARQ-1:0] base,
  input  logic [2*ARQ-1:0] modulo,
  input  logic [2*ARQ-1:0] exponent,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*ARQ-1:0] result,
  output logic             out_error,
  output logic             busy
);
  localparam int unsigned W  = 2 * ARQ;
  localparam int unsigned IW = $clog2(W);

  state_t        state, next_state;
  logic          accept_c, handshake_c, degenerate_c;
  logic [W-1:0]  b_q, m_q, e_q, r_q;
  logic [IW-1:0] idx_q;
  logic          err_q;

  logic          mul_start_c, mul_done;
  logic [W-1:0]  mul_a_c, mul_b_c, mul_m_c, mul_product, r_next_c;

  logic          in_ready_nx, out_valid_nx, out_error_nx, busy_nx;
  logic [W-1:0]  result_nx;

  assign accept_c     = in_valid & in_ready;
  assign handshake_c  = out_valid & out_ready;
  assign degenerate_c = (modulo <= W'(1)) || (exponent == '0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (accept_c) next_state = degenerate_c ? ST_DONE : ST_REDUCE;
      ST_REDUCE: if (mul_done) next_state = ST_SQR;
      ST_SQR: begin
        if (mul_done) begin
          if (e_q[idx_q])          next_state = ST_MUL;
          else if (idx_q == '0)    next_state = ST_DONE;
          else                     next_state = ST_SQR;
        end
      end
      ST_MUL:    if (mul_done) next_state = (idx_q == '0) ? ST_DONE : ST_SQR;
      ST_DONE:   if (handshake_c) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Output decode and multiplier sequencing; next phase launches on the
  // done cycle of the previous one using the fresh product.
  always_comb begin
    in_ready_nx  = (next_state == ST_IDLE);
    busy_nx      = (next_state != ST_IDLE);
    out_valid_nx = (state == ST_DONE) & ~handshake_c;
    out_error_nx = (state == ST_DONE) & err_q & ~handshake_c;
    result_nx    = (state == ST_DONE) ? r_q : result;

    r_next_c     = (state == ST_REDUCE) ? r_q : mul_product;
    mul_a_c      = r_next_c;
    mul_b_c      = (next_state == ST_MUL) ? b_q : r_next_c;
    mul_m_c      = m_q;
    mul_start_c  = mul_done && ((next_state == ST_SQR) || (next_state == ST_MUL));
    if (state == ST_IDLE) begin
      // Base reduction: 1 * base mod modulo.
      mul_a_c     = W'(1);
      mul_b_c     = base;
      mul_m_c     = modulo;
      mul_start_c = accept_c & ~degenerate_c;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_error <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      out_error <= out_error_nx;
      result    <= result_nx;
      busy      <= busy_nx;
    end
  end

  // Operand capture, running result R, reduced base B and bit index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_q   <= '0;
      m_q   <= '0;
      e_q   <= '0;
      r_q   <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept_c) begin
            b_q   <= '0;
            m_q   <= modulo;
            e_q   <= exponent;
            err_q <= (modulo == '0);
            // modulo 0/1 give 0; exponent 0 and the normal start both give 1.
            r_q   <= (modulo <= W'(1)) ? '0 : W'(1);
            idx_q <= SKIP_LEADING ? IW'(msb_index(MSB_MAX_W'(exponent))) : IW'(W - 1);
          end
        end
        ST_REDUCE: if (mul_done) b_q <= mul_product;
        ST_SQR, ST_MUL: begin
          if (mul_done) begin
            r_q <= mul_product;
            if (next_state == ST_SQR) idx_q <= idx_q - IW'(1);
          end
        end
        ST_DONE: if (handshake_c) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  mod_mul_serial #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (reset),
    .start   (mul_start_c),
    .a       (mul_a_c),
    .b       (mul_b_c),
    .m       (mul_m_c),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule
